// File: rtl/ccu_snoop_data_fwd.sv
`default_nettype none
// ============================================================================
//  Module   : ccu_snoop_data_fwd
//  Brief    : Snoop-data forwarder for the CCU control path. Consumes one
//             cache line of CD beats per command and returns the requested
//             word window on the slave R channel with ACE shared/dirty bits.
//             Also handles invalid-ack and drop-only commands, and flags CD
//             last-bit protocol errors.
//  Revision : 1.0 - initial release
// ============================================================================
module ccu_snoop_data_fwd #(
  parameter int unsigned AxiDataWidth    = 64,
  parameter int unsigned DcacheLineWidth = 256,
  parameter int unsigned FifoDepth       = 4,
  parameter int unsigned IdWidth         = 4,
  parameter int unsigned AddrWidth       = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // snoop-unit command
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [1:0]              req_op_i,
  input  logic [IdWidth-1:0]      req_id_i,
  input  logic [AddrWidth-1:0]    req_addr_i,
  input  logic [7:0]              req_len_i,
  input  logic                    req_shared_i,
  input  logic                    req_dirty_i,
  // CD snoop data beats
  input  logic                    cd_valid_i,
  output logic                    cd_ready_o,
  input  logic [AxiDataWidth-1:0] cd_data_i,
  input  logic                    cd_last_i,
  // slave R channel
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [AxiDataWidth-1:0] r_data_o,
  output logic [IdWidth-1:0]      r_id_o,
  output logic [3:0]              r_resp_o,
  output logic                    r_last_o,
  // status
  output logic                    proto_err_o,
  output logic                    busy_o
);

  // Beats per line and derived widths. The word counter is at least one bit
  // wide so a single-beat line still has a legal (constant zero) counter.
  localparam int unsigned c_n     = DcacheLineWidth / AxiDataWidth;
  localparam int unsigned c_kw    = (c_n > 1) ? $clog2(c_n) : 1;
  localparam int unsigned c_off   = $clog2(AxiDataWidth / 8);
  localparam int unsigned c_sw    = c_kw + 9;
  localparam int unsigned c_pw    = $clog2(FifoDepth);
  localparam int unsigned c_cw    = $clog2(FifoDepth + 1);
  localparam logic [c_kw-1:0] c_klast = c_kw'(c_n - 1);
  localparam logic [c_pw-1:0] c_plast = c_pw'(FifoDepth - 1);
  localparam logic [c_cw-1:0] c_full  = c_cw'(FifoDepth);

  localparam logic [1:0] c_op_read = 2'd1;
  localparam logic [1:0] c_op_drop = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e r_state, w_state_nxt;

  logic [IdWidth-1:0] r_id;
  logic               r_shared;
  logic               r_dirty;
  logic               r_read;        // 1: forward window, 0: drop-only
  logic [c_kw-1:0]    r_s;
  logic [c_kw-1:0]    r_e;
  logic [c_kw-1:0]    r_k;
  logic               r_line_done;
  logic               r_last_popped;
  logic               r_perr;

  // beat FIFO: {last tag, data}
  logic [AxiDataWidth:0] r_mem [FifoDepth];
  logic [c_pw-1:0]       r_wptr;
  logic [c_pw-1:0]       r_rptr;
  logic [c_cw-1:0]       r_cnt;

  logic              w_req_hs;
  logic [c_kw-1:0]   w_start;
  logic [c_sw-1:0]   w_sum;
  logic [c_kw-1:0]   w_end;
  logic              w_in_window;
  logic              w_full;
  logic              w_empty;
  logic              w_cd_hs;
  logic              w_k_last;
  logic              w_push;
  logic              w_pop;
  logic              w_head_last;
  logic              w_line_ended;
  logic              w_unused;

  // Start word is the word offset of the address inside the line.
  generate
    if (c_n > 1) begin : g_start_multi
      assign w_start = req_addr_i[c_off +: c_kw];
    end else begin : g_start_single
      assign w_start = '0;
    end
  endgenerate

  // Address bits outside the word offset carry no meaning here.
  assign w_unused = ^req_addr_i;

  // End word clipped to the last word of the line; wide sum avoids wrap.
  assign w_sum = c_sw'(w_start) + c_sw'(req_len_i);
  assign w_end = (w_sum >= c_sw'(c_n - 1)) ? c_klast : w_sum[c_kw-1:0];

  assign w_req_hs    = req_valid_i && req_ready_o;
  assign w_full      = (r_cnt == c_full);
  assign w_empty     = (r_cnt == '0);
  assign w_k_last    = (r_k == c_klast);
  assign w_in_window = r_read && (r_k >= r_s) && (r_k <= r_e);
  assign w_cd_hs     = cd_valid_i && cd_ready_o;
  assign w_push      = w_cd_hs && w_in_window;
  assign w_pop       = (r_state == ST_DATA) && !w_empty && r_ready_i;
  assign w_head_last = r_mem[r_rptr][AxiDataWidth];
  assign w_line_ended = r_line_done || (w_cd_hs && w_k_last);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (req_op_i == c_op_read || req_op_i == c_op_drop) begin
            w_state_nxt = ST_DATA;
          end else begin
            w_state_nxt = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (r_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (w_line_ended && (!r_read || r_last_popped || (w_pop && w_head_last))) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and R channel outputs
  always_comb begin
    req_ready_o = (r_state == ST_IDLE);
    cd_ready_o  = 1'b0;
    r_valid_o   = 1'b0;
    r_data_o    = '0;
    r_id_o      = '0;
    r_resp_o    = '0;
    r_last_o    = 1'b0;
    case (r_state)
      ST_ACK: begin
        r_valid_o = 1'b1;
        r_id_o    = r_id;
        r_last_o  = 1'b1;
      end
      ST_DATA: begin
        cd_ready_o = !r_line_done && (!w_in_window || !w_full);
        if (!w_empty) begin
          r_valid_o = 1'b1;
          r_data_o  = r_mem[r_rptr][AxiDataWidth-1:0];
          r_last_o  = w_head_last;
          r_id_o    = r_id;
          r_resp_o  = {r_shared, r_dirty, 2'b00};
        end
      end
      default: ;
    endcase
  end

  assign proto_err_o = r_perr;
  assign busy_o      = (r_state != ST_IDLE);

  // State register, command capture and CD line tracking
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_id          <= '0;
      r_shared      <= 1'b0;
      r_dirty       <= 1'b0;
      r_read        <= 1'b0;
      r_s           <= '0;
      r_e           <= '0;
      r_k           <= '0;
      r_line_done   <= 1'b0;
      r_last_popped <= 1'b0;
      r_perr        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_perr  <= w_cd_hs && (cd_last_i != w_k_last);
      if (w_req_hs) begin
        r_id          <= req_id_i;
        r_shared      <= req_shared_i;
        r_dirty       <= req_dirty_i;
        r_read        <= (req_op_i == c_op_read);
        r_s           <= w_start;
        r_e           <= w_end;
        r_k           <= '0;
        r_line_done   <= 1'b0;
        r_last_popped <= 1'b0;
      end else if (r_state == ST_DATA) begin
        if (w_cd_hs) begin
          if (w_k_last) begin
            r_line_done <= 1'b1;
          end else begin
            r_k <= r_k + c_kw'(1);
          end
        end
        if (w_pop && w_head_last) begin
          r_last_popped <= 1'b1;
        end
      end
    end
  end

  // FIFO pointers and occupancy; reset empties the FIFO
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == c_plast) ? '0 : r_wptr + c_pw'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_plast) ? '0 : r_rptr + c_pw'(1);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + c_cw'(1);
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - c_cw'(1);
      end
    end
  end

  // FIFO storage; the last tag marks the final word of the window
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= {(r_k == r_e), cd_data_i};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccu_snoop_data_fwd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ccu_snoop_data_fwd
//  Brief    : Directed self-checking bench for ccu_snoop_data_fwd with an
//             R-beat scoreboard (N=4, FifoDepth=2, 64-bit data).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ccu_snoop_data_fwd;

  localparam int unsigned c_dw = 64;
  localparam int unsigned c_iw = 4;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready_o;
  logic [1:0]       req_op;
  logic [c_iw-1:0]  req_id;
  logic [63:0]      req_addr;
  logic [7:0]       req_len;
  logic             req_shared;
  logic             req_dirty;
  logic             cd_valid;
  logic             cd_ready_o;
  logic [c_dw-1:0]  cd_data;
  logic             cd_last;
  logic             r_valid_o;
  logic             r_ready;
  logic [c_dw-1:0]  r_data_o;
  logic [c_iw-1:0]  r_id_o;
  logic [3:0]       r_resp_o;
  logic             r_last_o;
  logic             proto_err_o;
  logic             busy_o;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  resp;
  } rbeat_t;

  rbeat_t sb[$];
  rbeat_t exp_b;
  int     vectors     = 0;
  int     miscompares = 0;
  int     perr_cnt    = 0;
  int     cd_hs_cnt   = 0;
  int     hs0;
  int     pe0;

  ccu_snoop_data_fwd #(
    .AxiDataWidth    (64),
    .DcacheLineWidth (256),
    .FifoDepth       (2),
    .IdWidth         (4),
    .AddrWidth       (64)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op),
    .req_id_i     (req_id),
    .req_addr_i   (req_addr),
    .req_len_i    (req_len),
    .req_shared_i (req_shared),
    .req_dirty_i  (req_dirty),
    .cd_valid_i   (cd_valid),
    .cd_ready_o   (cd_ready_o),
    .cd_data_i    (cd_data),
    .cd_last_i    (cd_last),
    .r_valid_o    (r_valid_o),
    .r_ready_i    (r_ready),
    .r_data_o     (r_data_o),
    .r_id_o       (r_id_o),
    .r_resp_o     (r_resp_o),
    .r_last_o     (r_last_o),
    .proto_err_o  (proto_err_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic rbeat_t mk(input logic [63:0] d, input logic l, input logic [3:0] id,
                                input logic [3:0] rsp);
    rbeat_t b;
    b.data = d; b.last = l; b.id = id; b.resp = rsp;
    return b;
  endfunction

  // Monitor: counts CD handshakes and error pulses, scores R beats
  always @(negedge clk) begin
    if (rst_n) begin
      if (proto_err_o) perr_cnt++;
      if (cd_valid && cd_ready_o) cd_hs_cnt++;
      if (r_valid_o && sb.size() == 0) begin
        chk("r_unexpected", 80'(1), 80'(0));
      end else if (r_valid_o && r_ready) begin
        exp_b = sb.pop_front();
        chk("r_beat", 80'({r_data_o, r_last_o, r_id_o, r_resp_o}), 80'(exp_b));
      end
    end
  end

  // Issue one command; starts and ends just after a rising edge
  task automatic do_req(input logic [1:0] op, input logic [3:0] id, input logic [63:0] addr,
                        input logic [7:0] len, input logic sh, input logic dt);
    int t;
    req_valid = 1'b1; req_op = op; req_id = id; req_addr = addr;
    req_len = len; req_shared = sh; req_dirty = dt;
    t = 0;
    @(negedge clk);
    while (!req_ready_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready", 80'(req_ready_o), 80'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Drive nbeats CD beats (data base+i); cd_last flipped on beat err_idx
  task automatic send_line(input logic [63:0] base, input int nbeats, input int err_idx);
    int  t;
    bit  stop;
    stop = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (!stop) begin
        cd_valid = 1'b1;
        cd_data  = base + 64'(i);
        cd_last  = (i == 3) ^ (i == err_idx);
        t = 0;
        @(negedge clk);
        while (!cd_ready_o && t < 100) begin
          @(negedge clk);
          t++;
        end
        if (t >= 100) begin
          chk("cd_timeout", 80'(0), 80'(1));
          stop = 1'b1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
    cd_valid = 1'b0;
    cd_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (busy_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 80'(busy_o), 80'(0));
    chk("sb_drained", 80'(sb.size()), 80'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_id = '0; req_addr = '0;
    req_len = '0; req_shared = 1'b0; req_dirty = 1'b0; cd_valid = 1'b0;
    cd_data = '0; cd_last = 1'b0; r_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_r_valid", 80'(r_valid_o), 80'(0));
    chk("rst_cd_ready", 80'(cd_ready_o), 80'(0));
    chk("rst_perr", 80'(proto_err_o), 80'(0));
    chk("rst_busy", 80'(busy_o), 80'(0));
    chk("rst_req_ready", 80'(req_ready_o), 80'(1));
    chk("rst_payload", 80'({r_data_o, r_last_o, r_id_o, r_resp_o}), 80'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: invalid ack, R held for 3 cycles before ready
    r_ready = 1'b0;
    sb.push_back(mk(64'h0, 1'b1, 4'd5, 4'h0));
    do_req(2'd0, 4'd5, 64'h0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ack_valid", 80'(r_valid_o), 80'(1));
      chk("ack_payload", 80'({r_data_o, r_last_o, r_id_o, r_resp_o}),
          80'(mk(64'h0, 1'b1, 4'd5, 4'h0)));
      chk("ack_req_ready", 80'(req_ready_o), 80'(0));
    end
    @(posedge clk); #1;
    r_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ack_idle", 80'(busy_o), 80'(0));
    chk("ack_r_valid_low", 80'(r_valid_o), 80'(0));
    chk("ack_req_ready_back", 80'(req_ready_o), 80'(1));
    chk("sb_drained", 80'(sb.size()), 80'(0));
    @(posedge clk); #1;

    // 2: READ len=0 at word 2, shared
    r_ready = 1'b1;
    sb.push_back(mk(64'hA200, 1'b1, 4'd7, 4'b1000));
    do_req(2'd1, 4'd7, 64'h10, 8'd0, 1'b1, 1'b0);
    hs0 = cd_hs_cnt; pe0 = perr_cnt;
    send_line(64'hA200 - 64'd2, 4, -1);
    wait_idle("read0_idle");
    chk("read0_cd_hs", 80'(cd_hs_cnt - hs0), 80'(4));
    chk("read0_no_perr", 80'(perr_cnt - pe0), 80'(0));

    // 3: READ full line, dirty, R stalled so CD backpressures
    r_ready = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back(mk(64'hB000 + 64'(i), i == 3, 4'd3, 4'b0100));
    do_req(2'd1, 4'd3, 64'h0, 8'd3, 1'b0, 1'b1);
    fork
      send_line(64'hB000, 4, -1);
      begin
        repeat (4) @(negedge clk);
        chk("bp_cd_ready_low", 80'(cd_ready_o), 80'(0));
        chk("bp_r_valid", 80'(r_valid_o), 80'(1));
        @(posedge clk); #1;
        r_ready = 1'b1;
      end
    join
    wait_idle("read_full_idle");

    // 4: READ at word 2 with len clipped at line end
    r_ready = 1'b1;
    sb.push_back(mk(64'hC002, 1'b0, 4'd1, 4'b0000));
    sb.push_back(mk(64'hC003, 1'b1, 4'd1, 4'b0000));
    do_req(2'd1, 4'd1, 64'h10, 8'd3, 1'b0, 1'b0);
    send_line(64'hC000, 4, -1);
    wait_idle("clip_idle");

    // 5a: drop-only, no R traffic, IDLE right after beat 3
    hs0 = cd_hs_cnt; pe0 = perr_cnt;
    do_req(2'd2, 4'd4, 64'h0, 8'd3, 1'b1, 1'b1);
    send_line(64'hD000, 4, -1);
    @(negedge clk);
    chk("drop_idle", 80'(busy_o), 80'(0));
    chk("drop_cd_hs", 80'(cd_hs_cnt - hs0), 80'(4));
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;
    chk("drop_no_perr", 80'(perr_cnt - pe0), 80'(0));

    // 5b: drop with early cd_last on beat 1
    hs0 = cd_hs_cnt; pe0 = perr_cnt;
    do_req(2'd2, 4'd4, 64'h0, 8'd0, 1'b0, 1'b0);
    send_line(64'hE000, 4, 1);
    @(negedge clk);
    chk("perr_idle", 80'(busy_o), 80'(0));
    chk("perr_cd_hs", 80'(cd_hs_cnt - hs0), 80'(4));
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;
    chk("perr_once", 80'(perr_cnt - pe0), 80'(1));

    // 6: reset mid-DATA with one beat buffered, then a fresh READ
    r_ready = 1'b0;
    sb.push_back(mk(64'hF000, 1'b0, 4'd9, 4'b0000));
    do_req(2'd1, 4'd9, 64'h0, 8'd3, 1'b0, 1'b0);
    send_line(64'hF000, 1, -1);
    @(negedge clk);
    chk("pre_rst_r_valid", 80'(r_valid_o), 80'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_r_valid", 80'(r_valid_o), 80'(0));
    chk("mid_rst_cd_ready", 80'(cd_ready_o), 80'(0));
    chk("mid_rst_busy", 80'(busy_o), 80'(0));
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    r_ready = 1'b1;
    sb.push_back(mk(64'h9001, 1'b0, 4'd2, 4'b1100));
    sb.push_back(mk(64'h9002, 1'b1, 4'd2, 4'b1100));
    do_req(2'd1, 4'd2, 64'h08, 8'd1, 1'b1, 1'b1);
    send_line(64'h9000, 4, -1);
    wait_idle("post_rst_idle");

    // op 3 behaves like an invalid ack
    sb.push_back(mk(64'h0, 1'b1, 4'd6, 4'h0));
    do_req(2'd3, 4'd6, 64'h0, 8'd0, 1'b1, 1'b1);
    wait_idle("op3_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
